mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the five-stage RISC-V pipeline: the transmitting end of the M→W valid/allow-in handshake consumed by the write-back stage. It accepts one instruction from execute, issues at most one request on a valid/ready data-memory bus for loads and stores, and presents the instruction to write-back with `m_to_w_valid` once the access completes. Load data is aligned and sign/zero-extended here, so write-back receives the final `m_valM`.

## Interface
- No parameters.
- `clk  in  1`  clock.
- `rst  in  1`  reset, synchronous, active-high.
- `e_to_m_valid  in  1`  execute holds a valid instruction.
- `m_allow_in  out  1`  stage can accept this cycle.
- `m_valid  out  1`  stage register holds an instruction.
- `m_to_w_valid  out  1`  instruction complete, offered to write-back.
- `w_allow_in  in  1`  write-back accepts.
- `E_opcode 7`, `E_funct3 3`, `E_rd 5`, `E_valE 32` (ALU result / address), `E_valB 32` (store data), `E_default_pc`, `E_cur_pc`, `E_instr`, `E_pred_pc` (32 each), `E_commit 1`  all `in`; payload from execute.
- `M_opcode`, `M_rd`, `M_valE`, `M_default_pc`, `M_cur_pc`, `M_instr`, `M_pred_pc`, `M_commit`  `out`; registered copies, same widths.
- `m_valM  out  32`  extended load data; 0 for non-loads.
- `M_misalign  out  1`  current instruction is a misaligned load/store.
- `dmem_req_valid  out  1`, `dmem_req_ready  in  1`, `dmem_req_we  out  1`, `dmem_req_addr  out  32`, `dmem_req_wdata  out  32`, `dmem_req_wstrb  out  4`  request channel.
- `dmem_resp_valid  in  1`, `dmem_resp_rdata  in  32`  load response channel; no back-pressure.

## Operation
- Load: opcode 7'b0000011, funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store: opcode 7'b0100011, funct3 000 SB, 001 SH, 010 SW. Any other funct3 with these opcodes is treated as a non-memory instruction.
- Misaligned: halfword with addr[0]=1, word with addr[1:0]≠0. No bus request is issued; `M_misalign`=1, `m_valM`=0, completes as non-memory.
- States: IDLE, REQ, WAIT, DONE.
  - Stage load (`m_allow_in && e_to_m_valid`): payload captured, `m_valM`←0, `M_misalign` computed; next state is REQ for an aligned load/store, otherwise DONE.
  - REQ: `dmem_req_valid`=1. Address, we, wdata, and wstrb are driven from stage registers and held stable until ready. On `dmem_req_ready`: store → DONE (posted, no response); load → WAIT.
  - WAIT: on `dmem_resp_valid`, capture extended data into `m_valM` → DONE.
  - DONE: `m_ready_go`=1. On `w_allow_in`, go to IDLE, or take the per-load next state if a new instruction is captured in the same cycle.
- `m_allow_in = ~m_valid | (m_ready_go & w_allow_in)`; `m_to_w_valid = m_valid & m_ready_go`; `m_valid` updates to `e_to_m_valid` when `m_allow_in`.
- Request address = `{E_valE[31:2],2'b00}`, lane = addr[1:0].
  - SB: wdata = byte replicated ×4, wstrb = 1<<lane.
  - SH: halfword replicated ×2, wstrb = 0011 or 1100.
  - SW: wstrb = 1111.
  - Loads: we=0, wstrb=0000.
- Load extract: byte/halfword selected by lane from rdata; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- `dmem_resp_valid` outside WAIT is ignored.

## Timing
- Reset: state IDLE; `m_valid`, `m_to_w_valid`, `dmem_req_valid`, `M_misalign`, `M_commit` = 0; all 32-bit outputs and `M_opcode`/`M_rd` = 0; `dmem_req_we`=0, `dmem_req_wstrb`=0.
- Non-memory or misaligned: `m_to_w_valid` asserts the cycle after capture (1-cycle stage latency).
- Store: request the cycle after capture. If ready in that cycle, `m_to_w_valid` the next cycle.
- Load: request the cycle after capture; response ≥1 cycle after the ready handshake; `m_to_w_valid` and `m_valM` are valid the cycle after `dmem_resp_valid`.
- Back-to-back: in DONE with `w_allow_in`=1, a new instruction is accepted the same cycle, giving full throughput for non-memory streams.
- `w_allow_in`=0 in DONE: all M outputs and `m_valM` hold; `m_allow_in`=0.
- Reset mid-transaction (REQ/WAIT): returns to IDLE next edge, `dmem_req_valid` drops; a late response is dropped.
- Exactly one request per instruction; `dmem_req_valid` never reasserts for the same instruction.

## Test plan
- ADD (opcode 0110011), valE=0x1234, `w_allow_in`=1 -> `m_to_w_valid` 1 cycle after capture, `M_valE`=0x1234, `m_valM`=0, no bus request.
- LB addr 0x1003, rdata 0x80FF_0000, ready immediate, response 2 cycles later -> req addr 0x1000, wstrb 0000; `m_valM`=0xFFFF_FF80; LBU gives 0x0000_0080.
- SH addr 0x2002, valB 0xABCD_1234, `dmem_req_ready` low 3 cycles -> request held stable, wdata 0x1234_1234, wstrb 1100; `m_to_w_valid` the cycle after the handshake; no response awaited.
- LW addr 0x3001 -> no request, `M_misalign`=1, `m_valM`=0, `m_to_w_valid` after 1 cycle.
- Three back-to-back ADDs with `w_allow_in` low for 2 cycles on the second -> `m_allow_in`=0 during the stall, outputs held, all three retire in order with none lost or duplicated.
- `rst` pulsed in WAIT, then `dmem_resp_valid` -> `m_valid`=0, `m_valM`=0, no `m_to_w_valid`, `dmem_req_valid`=0.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the memory (slave).
// Request channel is valid/ready; load responses are a one-way valid pulse with no back-pressure.
interface mem_access_stage_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V memory-access stage: one dmem request per load/store, load data aligned and extended here.
// Latency 1 cycle for non-memory ops, more for memory ops; holds everything while write-back stalls.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        e_to_m_valid,
    output logic        m_allow_in,
    output logic        m_valid,
    output logic        m_to_w_valid,
    input  logic        w_allow_in,
    input  logic [6:0]  E_opcode,
    input  logic [2:0]  E_funct3,
    input  logic [4:0]  E_rd,
    input  logic [31:0] E_valE,
    input  logic [31:0] E_valB,
    input  logic [31:0] E_default_pc,
    input  logic [31:0] E_cur_pc,
    input  logic [31:0] E_instr,
    input  logic [31:0] E_pred_pc,
    input  logic        E_commit,
    output logic [6:0]  M_opcode,
    output logic [4:0]  M_rd,
    output logic [31:0] M_valE,
    output logic [31:0] M_default_pc,
    output logic [31:0] M_cur_pc,
    output logic [31:0] M_instr,
    output logic [31:0] M_pred_pc,
    output logic        M_commit,
    output logic [31:0] m_valM,
    output logic        M_misalign,
    mem_access_stage_if.master dmem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q;
    logic        m_valid_q;
    logic [6:0]  opcode_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic [31:0] valE_q;
    logic [31:0] default_pc_q;
    logic [31:0] cur_pc_q;
    logic [31:0] instr_q;
    logic [31:0] pred_pc_q;
    logic        commit_q;
    logic [31:0] valM_q;
    logic        misalign_q;
    logic        req_valid_q;
    logic        req_we_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_wstrb_q;

    logic        e_load;
    logic        e_store;
    logic        e_misalign;
    logic        e_mem_go;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic        m_ready_go;
    logic        capture;

    always_comb begin
        e_load     = (E_opcode == 7'b0000011) &&
                     (E_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        e_store    = (E_opcode == 7'b0100011) && (E_funct3 inside {3'b000, 3'b001, 3'b010});
        e_misalign = 1'b0;
        case (E_funct3[1:0])
            2'b01:   e_misalign = E_valE[0];
            2'b10:   e_misalign = |E_valE[1:0];
            default: e_misalign = 1'b0;
        endcase
        e_misalign = e_misalign & (e_load | e_store);
        e_mem_go   = (e_load | e_store) & ~e_misalign;
        e_wdata    = '0;
        e_wstrb    = '0;
        if (e_store) begin
            case (E_funct3[1:0])
                2'b00: begin
                    e_wdata = {4{E_valB[7:0]}};
                    e_wstrb = 4'b0001 << E_valE[1:0];
                end
                2'b01: begin
                    e_wdata = {2{E_valB[15:0]}};
                    e_wstrb = E_valE[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    e_wdata = E_valB;
                    e_wstrb = 4'b1111;
                end
            endcase
        end
    end

    assign m_ready_go   = (state_q == DONE);
    assign m_allow_in   = ~m_valid_q | (m_ready_go & w_allow_in);
    assign m_to_w_valid = m_valid_q & m_ready_go;
    assign capture      = m_allow_in & e_to_m_valid;

    // Byte/halfword lane selection and extension of the returned word.
    function automatic logic [31:0] load_ext(input logic [31:0] rdata,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{lane, 3'b000} +: 8];
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'b0, b};
            3'b101:  r = {16'b0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            m_valid_q    <= 1'b0;
            opcode_q     <= '0;
            funct3_q     <= '0;
            rd_q         <= '0;
            valE_q       <= '0;
            default_pc_q <= '0;
            cur_pc_q     <= '0;
            instr_q      <= '0;
            pred_pc_q    <= '0;
            commit_q     <= 1'b0;
            valM_q       <= '0;
            misalign_q   <= 1'b0;
            req_valid_q  <= 1'b0;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
        end else begin
            if (m_allow_in)
                m_valid_q <= e_to_m_valid;
            if (capture) begin
                opcode_q     <= E_opcode;
                funct3_q     <= E_funct3;
                rd_q         <= E_rd;
                valE_q       <= E_valE;
                default_pc_q <= E_default_pc;
                cur_pc_q     <= E_cur_pc;
                instr_q      <= E_instr;
                pred_pc_q    <= E_pred_pc;
                commit_q     <= E_commit;
                valM_q       <= '0;
                misalign_q   <= e_misalign;
                req_valid_q  <= e_mem_go;
                req_we_q     <= e_store;
                req_addr_q   <= {E_valE[31:2], 2'b00};
                req_wdata_q  <= e_wdata;
                req_wstrb_q  <= e_wstrb;
                state_q      <= e_mem_go ? REQ : DONE;
            end else begin
                case (state_q)
                    REQ: if (dmem.dmem_req_ready) begin
                        // Stores are posted: completion does not wait for any response.
                        req_valid_q <= 1'b0;
                        state_q     <= req_we_q ? DONE : WAIT;
                    end
                    WAIT: if (dmem.dmem_resp_valid) begin
                        valM_q  <= load_ext(dmem.dmem_resp_rdata, valE_q[1:0], funct3_q);
                        state_q <= DONE;
                    end
                    DONE: if (w_allow_in) state_q <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign m_valid             = m_valid_q;
    assign M_opcode            = opcode_q;
    assign M_rd                = rd_q;
    assign M_valE              = valE_q;
    assign M_default_pc        = default_pc_q;
    assign M_cur_pc            = cur_pc_q;
    assign M_instr             = instr_q;
    assign M_pred_pc           = pred_pc_q;
    assign M_commit            = commit_q;
    assign m_valM              = valM_q;
    assign M_misalign          = misalign_q;
    assign dmem.dmem_req_valid = req_valid_q;
    assign dmem.dmem_req_we    = req_we_q;
    assign dmem.dmem_req_addr  = req_addr_q;
    assign dmem.dmem_req_wdata = req_wdata_q;
    assign dmem.dmem_req_wstrb = req_wstrb_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: random and directed instructions against a behavioural model,
// with a scoreboard monitor on write-back and a memory responder on the dmem bus.
module tb_mem_access_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        e_to_m_valid = 1'b0, w_allow_in = 1'b1;
    logic        m_allow_in, m_valid, m_to_w_valid;
    logic [6:0]  E_opcode = '0;
    logic [2:0]  E_funct3 = '0;
    logic [4:0]  E_rd = '0;
    logic [31:0] E_valE = '0, E_valB = '0, E_default_pc = '0, E_cur_pc = '0, E_instr = '0, E_pred_pc = '0;
    logic        E_commit = 1'b0;
    logic [6:0]  M_opcode;
    logic [4:0]  M_rd;
    logic [31:0] M_valE, M_default_pc, M_cur_pc, M_instr, M_pred_pc, m_valM;
    logic        M_commit, M_misalign;

    mem_access_stage_if dmem_bus();

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .e_to_m_valid(e_to_m_valid), .m_allow_in(m_allow_in), .m_valid(m_valid),
        .m_to_w_valid(m_to_w_valid), .w_allow_in(w_allow_in),
        .E_opcode(E_opcode), .E_funct3(E_funct3), .E_rd(E_rd), .E_valE(E_valE), .E_valB(E_valB),
        .E_default_pc(E_default_pc), .E_cur_pc(E_cur_pc), .E_instr(E_instr), .E_pred_pc(E_pred_pc),
        .E_commit(E_commit),
        .M_opcode(M_opcode), .M_rd(M_rd), .M_valE(M_valE), .M_default_pc(M_default_pc),
        .M_cur_pc(M_cur_pc), .M_instr(M_instr), .M_pred_pc(M_pred_pc), .M_commit(M_commit),
        .m_valM(m_valM), .M_misalign(M_misalign),
        .dmem(dmem_bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [31:0] valE, dpc, cpc, instr, ppc, valM;
        logic        commit, mis;
    } exp_t;

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  wstrb;
        logic        we, is_load;
        int          cyc;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   done_q[$];

    int          wprob = 100;
    int          w_low = 0;
    int          rdy_hold = 0;
    bit          force_no_resp = 0;
    bit          late_req = 0;
    bit          pending = 0;
    int          delay = 0;
    logic [31:0] pend_rdata = '0;

    initial begin
        dmem_bus.dmem_req_ready  = 1'b0;
        dmem_bus.dmem_resp_valid = 1'b0;
        dmem_bus.dmem_resp_rdata = '0;
    end

    task automatic drive_w();
        if (w_low > 0) begin
            w_low--;
            w_allow_in = 1'b0;
        end else begin
            w_allow_in = ($urandom_range(0, 99) < wprob);
        end
    endtask

    // Present one instruction, wait for acceptance, then record what the stage must do with it.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] valE,
                         input logic [31:0] valB, input logic [31:0] rdata);
        int t;
        exp_t e;
        req_t r;
        int size;
        int lane;
        bit ld, st;
        logic [31:0] v, mask;
        E_opcode = op; E_funct3 = f3; E_valE = valE; E_valB = valB;
        E_rd = 5'($urandom); E_default_pc = $urandom; E_cur_pc = $urandom;
        E_instr = $urandom; E_pred_pc = $urandom; E_commit = 1'($urandom);
        e_to_m_valid = 1'b1;
        drive_w();
        t = 0;
        forever begin
            #1;
            if (m_allow_in) break;
            if (t >= 200) begin
                fail_event("capture_timeout");
                e_to_m_valid = 1'b0;
                return;
            end
            @(negedge clk);
            drive_w();
            t++;
        end
        ld   = (op == 7'b0000011) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        st   = (op == 7'b0100011) && (f3 <= 3'd2);
        size = 1 << (f3 % 4);
        lane = int'(valE % 32'd4);
        e.op = op; e.rd = E_rd; e.valE = valE; e.dpc = E_default_pc; e.cpc = E_cur_pc;
        e.instr = E_instr; e.ppc = E_pred_pc; e.commit = E_commit; e.valM = '0;
        e.mis = (ld || st) && ((valE % 32'(size)) != 0);
        if ((ld || st) && !e.mis) begin
            r.addr = valE - 32'(lane); r.we = st; r.is_load = ld; r.rdata = rdata; r.cyc = cyc + 1;
            r.wstrb = '0; r.wdata = '0;
            if (st) begin
                r.wstrb = 4'(((1 << size) - 1) << lane);
                if (size == 1)      r.wdata = (valB & 32'hFF) * 32'h0101_0101;
                else if (size == 2) r.wdata = (valB & 32'hFFFF) * 32'h0001_0001;
                else                r.wdata = valB;
            end else begin
                mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
                v = (rdata >> (8 * lane)) & mask;
                if (f3 < 3'd4 && size < 4 && v[8 * size - 1]) v = v - (32'd1 << (8 * size));
                e.valM = v;
            end
            req_q.push_back(r);
        end else begin
            done_q.push_back(cyc + 1);
        end
        exp_q.push_back(e);
        @(negedge clk);
        e_to_m_valid = 1'b0;
        drive_w();
    endtask

    task automatic idle(input int n);
        e_to_m_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            drive_w();
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        e_to_m_valid = 1'b0;
        while ((exp_q.size() > 0 || req_q.size() > 0) && t < 300) begin
            @(negedge clk);
            drive_w();
            t++;
        end
        check({name, "_drain_left"}, 32'(exp_q.size() + req_q.size()), 32'd0);
    endtask

    // Memory responder: random ready, delayed load responses, stray response pulses.
    initial begin : responder
        bit   prev_vld = 0, prev_hs = 0, have_cur = 0;
        req_t cur;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_wstrb;
        logic        s_we;
        forever begin
            @(negedge clk);
            if (rdy_hold > 0) begin
                rdy_hold--;
                dmem_bus.dmem_req_ready = 1'b0;
            end else begin
                dmem_bus.dmem_req_ready = ($urandom_range(0, 99) < 70);
            end
            dmem_bus.dmem_resp_valid = 1'b0;
            dmem_bus.dmem_resp_rdata = $urandom;
            if (late_req) begin
                dmem_bus.dmem_resp_valid = 1'b1;
                late_req = 0;
            end else if (pending && !force_no_resp) begin
                delay--;
                if (delay == 0) begin
                    dmem_bus.dmem_resp_valid = 1'b1;
                    dmem_bus.dmem_resp_rdata = pend_rdata;
                    pending = 0;
                    done_q.push_back(cyc + 1);
                end
            end else if (!pending && $urandom_range(0, 99) < 10) begin
                dmem_bus.dmem_resp_valid = 1'b1;
            end
            #1;
            if (rst) begin
                pending = 0; prev_vld = 0; prev_hs = 0; have_cur = 0;
                continue;
            end
            if (dmem_bus.dmem_req_valid) begin
                if (!prev_vld || prev_hs) begin
                    if (req_q.size() == 0) begin
                        fail_event("unexpected_request");
                    end else begin
                        cur = req_q.pop_front();
                        have_cur = 1;
                        check("req_cycle", 32'(cyc), 32'(cur.cyc));
                        check("req_addr", dmem_bus.dmem_req_addr, cur.addr);
                        check("req_we", 32'(dmem_bus.dmem_req_we), 32'(cur.we));
                        check("req_wstrb", 32'(dmem_bus.dmem_req_wstrb), 32'(cur.wstrb));
                        if (cur.we) check("req_wdata", dmem_bus.dmem_req_wdata, cur.wdata);
                    end
                end else begin
                    check("req_hold_addr", dmem_bus.dmem_req_addr, s_addr);
                    check("req_hold_wdata", dmem_bus.dmem_req_wdata, s_wdata);
                    check("req_hold_wstrb", 32'(dmem_bus.dmem_req_wstrb), 32'(s_wstrb));
                    check("req_hold_we", 32'(dmem_bus.dmem_req_we), 32'(s_we));
                end
                s_addr = dmem_bus.dmem_req_addr; s_wdata = dmem_bus.dmem_req_wdata;
                s_wstrb = dmem_bus.dmem_req_wstrb; s_we = dmem_bus.dmem_req_we;
                if (dmem_bus.dmem_req_ready && have_cur) begin
                    if (cur.is_load) begin
                        pending = 1;
                        delay = $urandom_range(1, 3);
                        pend_rdata = cur.rdata;
                    end else begin
                        done_q.push_back(cyc + 1);
                    end
                    have_cur = 0;
                end
            end
            prev_vld = dmem_bus.dmem_req_valid;
            prev_hs  = dmem_bus.dmem_req_valid && dmem_bus.dmem_req_ready;
        end
    end

    // Write-back side monitor: completion timing, stall hold, in-order retirement.
    initial begin : monitor
        bit   prev_vld = 0, prev_ret = 0, have_snap = 0;
        exp_t x;
        logic [31:0] s_valE, s_valM, s_cpc;
        logic [4:0]  s_rd;
        logic        s_mis;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_vld = 0; prev_ret = 0; have_snap = 0;
                continue;
            end
            if (m_to_w_valid) begin
                if (!prev_vld || prev_ret) begin
                    if (done_q.size() == 0) fail_event("unexpected_complete");
                    else check("complete_cycle", 32'(cyc), 32'(done_q.pop_front()));
                end else if (have_snap) begin
                    check("hold_valE", M_valE, s_valE);
                    check("hold_valM", m_valM, s_valM);
                    check("hold_cur_pc", M_cur_pc, s_cpc);
                    check("hold_rd", 32'(M_rd), 32'(s_rd));
                    check("hold_misalign", 32'(M_misalign), 32'(s_mis));
                end
                check("allow_in_done", 32'(m_allow_in), 32'(w_allow_in));
                if (w_allow_in) begin
                    have_snap = 0;
                    if (exp_q.size() == 0) begin
                        fail_event("unexpected_retire");
                    end else begin
                        x = exp_q.pop_front();
                        check("ret_opcode", 32'(M_opcode), 32'(x.op));
                        check("ret_rd", 32'(M_rd), 32'(x.rd));
                        check("ret_valE", M_valE, x.valE);
                        check("ret_default_pc", M_default_pc, x.dpc);
                        check("ret_cur_pc", M_cur_pc, x.cpc);
                        check("ret_instr", M_instr, x.instr);
                        check("ret_pred_pc", M_pred_pc, x.ppc);
                        check("ret_commit", 32'(M_commit), 32'(x.commit));
                        check("ret_misalign", 32'(M_misalign), 32'(x.mis));
                        check("ret_valM", m_valM, x.valM);
                    end
                end else begin
                    have_snap = 1;
                    s_valE = M_valE; s_valM = m_valM; s_cpc = M_cur_pc; s_rd = M_rd; s_mis = M_misalign;
                end
            end else begin
                have_snap = 0;
                if (m_valid) check("allow_in_busy", 32'(m_allow_in), 32'd0);
            end
            prev_vld = m_to_w_valid;
            prev_ret = m_to_w_valid && w_allow_in;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [6:0] ops [6];
        int t;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011, 7'b0100011};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_to_w_valid", 32'(m_to_w_valid), 32'd0);
        check("rst_m_allow_in", 32'(m_allow_in), 32'd1);
        check("rst_req_valid", 32'(dmem_bus.dmem_req_valid), 32'd0);
        check("rst_req_we", 32'(dmem_bus.dmem_req_we), 32'd0);
        check("rst_req_wstrb", 32'(dmem_bus.dmem_req_wstrb), 32'd0);
        check("rst_req_addr", dmem_bus.dmem_req_addr, 32'd0);
        check("rst_misalign", 32'(M_misalign), 32'd0);
        check("rst_commit", 32'(M_commit), 32'd0);
        check("rst_valE", M_valE, 32'd0);
        check("rst_valM", m_valM, 32'd0);
        check("rst_opcode", 32'(M_opcode), 32'd0);
        check("rst_rd", 32'(M_rd), 32'd0);
        check("rst_cur_pc", M_cur_pc, 32'd0);

        // Directed cases
        wprob = 100;
        issue(7'b0110011, 3'b000, 32'h0000_1234, 32'h5555_5555, 32'h0);
        drain("add");
        issue(7'b0000011, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000);
        drain("lb");
        issue(7'b0000011, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_0000);
        drain("lbu");
        rdy_hold = 4;
        issue(7'b0100011, 3'b001, 32'h0000_2002, 32'hABCD_1234, 32'h0);
        drain("sh");
        issue(7'b0000011, 3'b010, 32'h0000_3001, 32'h0, 32'hDEAD_BEEF);
        drain("lw_misalign");
        issue(7'b0110011, 3'b000, 32'h0000_0011, 32'h0, 32'h0);
        issue(7'b0110011, 3'b000, 32'h0000_0022, 32'h0, 32'h0);
        w_low = 2;
        issue(7'b0110011, 3'b000, 32'h0000_0033, 32'h0, 32'h0);
        drain("add_stall");

        // Reset while a load waits for its response; the late response must vanish.
        force_no_resp = 1;
        issue(7'b0000011, 3'b010, 32'h0000_4000, 32'h0, 32'h1234_5678);
        t = 0;
        while (!pending && t < 100) begin
            @(negedge clk);
            drive_w();
            t++;
        end
        if (!pending) fail_event("wait_state_timeout");
        rst = 1'b1;
        e_to_m_valid = 1'b0;
        exp_q.delete();
        done_q.delete();
        req_q.delete();
        @(negedge clk);
        rst = 1'b0;
        late_req = 1;
        #1;
        check("wrst_m_valid", 32'(m_valid), 32'd0);
        check("wrst_m_valM", m_valM, 32'd0);
        check("wrst_req_valid", 32'(dmem_bus.dmem_req_valid), 32'd0);
        repeat (4) begin
            @(negedge clk);
            drive_w();
            #1;
            check("wrst_m_to_w_valid", 32'(m_to_w_valid), 32'd0);
            check("wrst_req_valid_after", 32'(dmem_bus.dmem_req_valid), 32'd0);
        end
        force_no_resp = 0;

        // Randomized stream
        wprob = 70;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] va;
            va = $urandom;
            if ($urandom_range(0, 1) == 0) va = va & 32'h0000_FFFF;
            idle(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            issue(ops[$urandom_range(0, 5)], 3'($urandom), va, $urandom, $urandom);
        end
        wprob = 80;
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
